// File: rtl/exe_w6_sequencer.sv
// exe_w6_sequencer: buffers operation requests in a small FIFO and issues
// them one at a time to an exe_unit_w6. It waits the unit's fixed latency,
// captures the result, and returns it through a valid/ready response port
// in command order.
module exe_w6_sequencer #(
  parameter int BITS  = 8,
  parameter int DEPTH = 4,
  parameter int LAT   = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  logic [BITS-1:0]            i_cmd_a,
  input  logic [BITS-1:0]            i_cmd_b,
  input  logic [1:0]                 i_cmd_op,
  output logic [BITS-1:0]            o_exe_a,
  output logic [BITS-1:0]            o_exe_b,
  output logic [1:0]                 o_exe_op,
  input  logic [BITS-1:0]            i_exe_out,
  input  logic [3:0]                 i_exe_status,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [BITS-1:0]            o_rsp_out,
  output logic [3:0]                 o_rsp_status,
  output logic [1:0]                 o_rsp_op,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic [15:0]                o_done_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam int EW = 2 * BITS + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [EW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic            full_s, push_s, pop_s;
  logic [EW-1:0]   head_s;

  // Sequencer state and registered outputs
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] exe_a_q, exe_a_d, exe_b_q, exe_b_d;
  logic [1:0]      exe_op_q, exe_op_d;
  logic [BITS-1:0] rsp_out_q, rsp_out_d;
  logic [3:0]      rsp_status_q, rsp_status_d;
  logic [1:0]      rsp_op_q, rsp_op_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [15:0]     done_q, done_d;

  // Occupancy comes from the registered level only, so a freshly pushed
  // command can never be popped in the same cycle (no bypass path).
  assign full_s = (level_q == LW'(DEPTH));
  assign push_s = i_cmd_valid && !full_s;
  assign pop_s  = (state_q == S_IDLE) && (level_q != {LW{1'b0}});
  assign head_s = mem_q[rd_ptr_q];

  // Write accepted commands into the FIFO array (data path, no reset needed)
  always_ff @(posedge i_clk) begin
    if (push_s && !i_rst) begin
      mem_q[wr_ptr_q] <= {i_cmd_op, i_cmd_b, i_cmd_a};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Next-state logic: issue from IDLE, count out the unit latency, hold the response
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    exe_a_d      = exe_a_q;
    exe_b_d      = exe_b_q;
    exe_op_d     = exe_op_q;
    rsp_out_d    = rsp_out_q;
    rsp_status_d = rsp_status_q;
    rsp_op_d     = rsp_op_q;
    done_d       = done_q;
    case (state_q)
      S_IDLE: begin
        if (pop_s) begin
          exe_a_d  = head_s[BITS-1:0];
          exe_b_d  = head_s[2*BITS-1:BITS];
          exe_op_d = head_s[EW-1:2*BITS];
          cnt_d    = CW'(LAT);
          state_d  = S_WAIT;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == {CW{1'b0}}) begin
          rsp_out_d    = i_exe_out;
          rsp_status_d = i_exe_status;
          rsp_op_d     = exe_op_q;
          state_d      = S_RESP;
        end else begin
          cnt_d        = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          done_d  = done_q + 16'd1;
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    rsp_valid_d = (state_d == S_RESP);
  end

  // State and output registers; reset discards any in-flight operation
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CW{1'b0}};
      exe_a_q      <= {BITS{1'b0}};
      exe_b_q      <= {BITS{1'b0}};
      exe_op_q     <= 2'b00;
      rsp_out_q    <= {BITS{1'b0}};
      rsp_status_q <= 4'h0;
      rsp_op_q     <= 2'b00;
      rsp_valid_q  <= 1'b0;
      done_q       <= 16'h0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      exe_a_q      <= exe_a_d;
      exe_b_q      <= exe_b_d;
      exe_op_q     <= exe_op_d;
      rsp_out_q    <= rsp_out_d;
      rsp_status_q <= rsp_status_d;
      rsp_op_q     <= rsp_op_d;
      rsp_valid_q  <= rsp_valid_d;
      done_q       <= done_d;
    end
  end

  assign o_cmd_ready  = !full_s;
  assign o_level      = level_q;
  assign o_exe_a      = exe_a_q;
  assign o_exe_b      = exe_b_q;
  assign o_exe_op     = exe_op_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_out    = rsp_out_q;
  assign o_rsp_status = rsp_status_q;
  assign o_rsp_op     = rsp_op_q;
  assign o_done_cnt   = done_q;

endmodule
